// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state, requester id and read tag.
package mem_arb_pkg;

  typedef enum logic {
    PRIO_D,
    PRIO_I
  } arb_state_t;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } arb_port_t;

  typedef struct packed {
    logic      valid;
    arb_port_t port;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// MEM_LATENCY-deep shift register of read tags; flush kills fetch-owned entries,
// including the tail being presented this cycle, but never the entry pushed now.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push_valid,
  input  arb_port_t push_port,
  output rd_tag_t   tail
);

  rd_tag_t [DEPTH-1:0] pipe_q;
  rd_tag_t [DEPTH-1:0] pipe_d;

  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = push_valid;
    pipe_d[0].port  = push_port;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      pipe_d[k] = pipe_q[k-1];
      if (flush && (pipe_q[k-1].port == PORT_I)) begin
        pipe_d[k].valid = 1'b0;
      end
    end
  end

  always_comb begin
    tail = pipe_q[DEPTH-1];
    if (reset || (flush && (pipe_q[DEPTH-1].port == PORT_I))) begin
      tail.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data has priority, fetch forced after STARVE_LIMIT denials.
// Optional MEM_ARB_PERF_CNT_EN adds conflict_cnt / force_cnt outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       force_cnt
`endif
);

  localparam int unsigned      CNT_W   = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  rd_tag_t          tail;

  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!reset) begin
      if (state_q == PRIO_I) begin
        i_gnt = i_req;
        d_gnt = d_req && !i_req;
      end else begin
        d_gnt = d_req;
        i_gnt = i_req && !d_req;
      end
    end
  end

  always_comb begin
    mem_en    = d_gnt || i_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
      end
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  // Leaving PRIO_I always restarts the count, whether fetch was served or withdrew.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      PRIO_D: begin
        if (i_gnt || !i_req) begin
          starve_cnt_d = '0;
        end else begin
          if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
          if ((STARVE_LIMIT > 0) && (starve_cnt_d == CNT_MAX)) begin
            state_d = PRIO_I;
          end
        end
      end
      PRIO_I: begin
        state_d      = PRIO_D;
        starve_cnt_d = '0;
      end
      default: begin
        state_d      = PRIO_D;
        starve_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PRIO_D;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_arb_tag_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_flush),
    .push_valid(mem_en && !mem_we),
    .push_port (i_gnt ? PORT_I : PORT_D),
    .tail      (tail)
  );

  assign d_rvalid = tail.valid && (tail.port == PORT_D);
  assign i_rvalid = tail.valid && (tail.port == PORT_I);
  assign d_rdata  = mem_rdata;
  assign i_rdata  = mem_rdata;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] force_cnt_q, force_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q + {31'd0, d_req && i_req};
    force_cnt_d    = force_cnt_q + {31'd0, i_gnt && (state_q == PRIO_I)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
      force_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      force_cnt_q    <= force_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign force_cnt    = force_cnt_q;
`endif

endmodule
